// File: rtl/arm_pipe_pkg.sv
// Shared MEM->WB pipeline types: the buffered entry layout and the write-back value select.
package arm_pipe_pkg;

  localparam int DATA_W_DEF = 32;
  localparam int DEST_W_DEF = 4;

  typedef struct packed {
    logic                  wb_en;
    logic                  mem_r_en;
    logic [DATA_W_DEF-1:0] alu_result;
    logic [DATA_W_DEF-1:0] mem_read_value;
    logic [DEST_W_DEF-1:0] dest;
  } mem_wb_t;

  // Loads write back the memory value, everything else writes back the ALU result.
  function automatic logic [DATA_W_DEF-1:0] wb_select(input mem_wb_t e);
    return e.mem_r_en ? e.mem_read_value : e.alu_result;
  endfunction

endpackage

// File: rtl/elastic_fifo_ctrl.sv
// Pointer/occupancy control for a DEPTH-entry elastic buffer with registered ready/valid and flush.
module elastic_fifo_ctrl #(
  parameter int  DEPTH = 2,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             i_flush,
  input  logic             i_in_valid,
  input  logic             i_out_ready,
  output logic             o_push,
  output logic [PTR_W-1:0] o_wr_ptr,
  output logic [PTR_W-1:0] o_rd_ptr,
  output logic [CNT_W-1:0] o_count,
  output logic             o_in_ready,
  output logic             o_out_valid
);

  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic             r_in_ready;
  logic             r_out_valid;

  logic             w_push;
  logic             w_pop;
  logic [CNT_W-1:0] w_count_nxt;

  // Ready is registered, so a pop never opens a slot for a push in the same cycle.
  always_comb begin
    w_push      = i_in_valid & r_in_ready & ~i_flush;
    w_pop       = r_out_valid & i_out_ready & ~i_flush;
    w_count_nxt = r_count;
    if (i_flush) begin
      w_count_nxt = '0;
    end else begin
      case ({w_push, w_pop})
        2'b10:   w_count_nxt = r_count + CNT_W'(1);
        2'b01:   w_count_nxt = r_count - CNT_W'(1);
        default: w_count_nxt = r_count;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_count     <= '0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
    end else begin
      r_count     <= w_count_nxt;
      r_in_ready  <= (w_count_nxt < CNT_W'(DEPTH));
      r_out_valid <= (w_count_nxt != '0);
      if (i_flush) begin
        r_wr_ptr <= '0;
        r_rd_ptr <= '0;
      end else begin
        if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
        if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      end
    end
  end

  assign o_push      = w_push;
  assign o_wr_ptr    = r_wr_ptr;
  assign o_rd_ptr    = r_rd_ptr;
  assign o_count     = r_count;
  assign o_in_ready  = r_in_ready;
  assign o_out_valid = r_out_valid;

endmodule

// File: rtl/mem_wb_elastic_reg.sv
// MEM->WB elastic stage register: DEPTH-entry FIFO of mem_wb_t with gated head outputs and wb_value mux.
module mem_wb_elastic_reg
  import arm_pipe_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int DEST_W = 4,
  parameter int DEPTH  = 2,
  parameter int WB_SEL = 1
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     flush,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic                     wb_en_in,
  input  logic                     mem_r_en_in,
  input  logic [DATA_W-1:0]        alu_result_in,
  input  logic [DATA_W-1:0]        mem_read_value_in,
  input  logic [DEST_W-1:0]        dest_in,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic                     wb_en,
  output logic                     mem_r_en,
  output logic [DATA_W-1:0]        alu_result,
  output logic [DATA_W-1:0]        mem_read_value,
  output logic [DEST_W-1:0]        dest,
  output logic [DATA_W-1:0]        wb_value,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PTR_W = $clog2(DEPTH);

  logic             w_push;
  logic [PTR_W-1:0] w_wr_ptr;
  logic [PTR_W-1:0] w_rd_ptr;
  logic             w_out_valid;
  logic             w_in_ready;
  logic [PTR_W:0]   w_count;
  mem_wb_t          w_in;
  mem_wb_t          w_head;
  logic [DATA_W-1:0] w_wb_sel;

  mem_wb_t r_mem [DEPTH];

  elastic_fifo_ctrl #(
    .DEPTH (DEPTH)
  ) u_ctrl (
    .clk         (clk),
    .reset_n     (reset_n),
    .i_flush     (flush),
    .i_in_valid  (in_valid),
    .i_out_ready (out_ready),
    .o_push      (w_push),
    .o_wr_ptr    (w_wr_ptr),
    .o_rd_ptr    (w_rd_ptr),
    .o_count     (w_count),
    .o_in_ready  (w_in_ready),
    .o_out_valid (w_out_valid)
  );

  always_comb begin
    w_in                = '0;
    w_in.wb_en          = wb_en_in;
    w_in.mem_r_en       = mem_r_en_in;
    w_in.alu_result     = DATA_W_DEF'(alu_result_in);
    w_in.mem_read_value = DATA_W_DEF'(mem_read_value_in);
    w_in.dest           = DEST_W_DEF'(dest_in);
  end

  // Storage carries no reset: every visible field is gated by out_valid, which does.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[w_wr_ptr] <= w_in;
  end

  assign w_head = r_mem[w_rd_ptr];

  generate
    if (WB_SEL != 0) begin : g_wb_sel
      assign w_wb_sel = DATA_W'(wb_select(w_head));
    end else begin : g_wb_zero
      assign w_wb_sel = '0;
    end
  endgenerate

  // Empty head drives all-zero fields so the register file never sees a stray write.
  assign wb_en          = w_out_valid & w_head.wb_en;
  assign mem_r_en       = w_out_valid & w_head.mem_r_en;
  assign alu_result     = w_out_valid ? DATA_W'(w_head.alu_result)     : '0;
  assign mem_read_value = w_out_valid ? DATA_W'(w_head.mem_read_value) : '0;
  assign dest           = w_out_valid ? DEST_W'(w_head.dest)           : '0;
  assign wb_value       = w_out_valid ? w_wb_sel                       : '0;

  assign out_valid = w_out_valid;
  assign in_ready  = w_in_ready;
  assign count     = w_count;

endmodule

// File: tb/tb_mem_wb_elastic_reg.sv
// Directed bench for mem_wb_elastic_reg (DATA_W=32, DEST_W=4, DEPTH=2, WB_SEL=1).
module tb_mem_wb_elastic_reg;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic        wb_en_in;
  logic        mem_r_en_in;
  logic [31:0] alu_result_in;
  logic [31:0] mem_read_value_in;
  logic [3:0]  dest_in;
  logic        out_valid;
  logic        out_ready;
  logic        wb_en;
  logic        mem_r_en;
  logic [31:0] alu_result;
  logic [31:0] mem_read_value;
  logic [3:0]  dest;
  logic [31:0] wb_value;
  logic [1:0]  count;

  int tests = 0;
  int failed = 0;

  mem_wb_elastic_reg #(
    .DATA_W (32),
    .DEST_W (4),
    .DEPTH  (2),
    .WB_SEL (1)
  ) dut (
    .clk               (clk),
    .reset_n           (reset_n),
    .flush             (flush),
    .in_valid          (in_valid),
    .in_ready          (in_ready),
    .wb_en_in          (wb_en_in),
    .mem_r_en_in       (mem_r_en_in),
    .alu_result_in     (alu_result_in),
    .mem_read_value_in (mem_read_value_in),
    .dest_in           (dest_in),
    .out_valid         (out_valid),
    .out_ready         (out_ready),
    .wb_en             (wb_en),
    .mem_r_en          (mem_r_en),
    .alu_result        (alu_result),
    .mem_read_value    (mem_read_value),
    .dest              (dest),
    .wb_value          (wb_value),
    .count             (count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic we, input logic mr,
                       input logic [31:0] alu, input logic [31:0] mrv, input logic [3:0] d);
    in_valid          = v;
    wb_en_in          = we;
    mem_r_en_in       = mr;
    alu_result_in     = alu;
    mem_read_value_in = mrv;
    dest_in           = d;
  endtask

  task automatic chk_empty(input string tag);
    chk({tag, "_ov"},    {31'd0, out_valid}, 32'd0);
    chk({tag, "_cnt"},   {30'd0, count}, 32'd0);
    chk({tag, "_rdy"},   {31'd0, in_ready}, 32'd1);
    chk({tag, "_zero"},  {31'd0, (wb_en | mem_r_en | (|alu_result) | (|mem_read_value) |
                                  (|dest) | (|wb_value))}, 32'd0);
  endtask

  initial begin
    reset_n   = 1'b0;
    flush     = 1'b0;
    out_ready = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    tick();
    tick();
    chk_empty("reset");
    #2 reset_n = 1'b1;
    tick();

    // Single push then pop
    out_ready = 1'b1;
    drive(1'b1, 1'b1, 1'b0, 32'h1234, 32'h0, 4'd3);
    tick();
    chk("single_ov",   {31'd0, out_valid}, 32'd1);
    chk("single_alu",  alu_result, 32'h1234);
    chk("single_dest", {28'd0, dest}, 32'd3);
    chk("single_wben", {31'd0, wb_en}, 32'd1);
    chk("single_mren", {31'd0, mem_r_en}, 32'd0);
    chk("single_mrv",  mem_read_value, 32'h0);
    chk("single_wbv",  wb_value, 32'h1234);
    chk("single_cnt",  {30'd0, count}, 32'd1);
    drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    tick();
    chk_empty("single_pop");

    // Fill with stall
    out_ready = 1'b0;
    drive(1'b1, 1'b1, 1'b0, 32'hA, 32'h0, 4'd1);
    tick();
    drive(1'b1, 1'b1, 1'b0, 32'hB, 32'h0, 4'd2);
    tick();
    chk("fill_cnt", {30'd0, count}, 32'd2);
    chk("fill_rdy", {31'd0, in_ready}, 32'd0);
    drive(1'b1, 1'b1, 1'b0, 32'hC, 32'h0, 4'd4);
    tick();
    chk("fill_cnt_hold", {30'd0, count}, 32'd2);
    chk("fill_head_a", alu_result, 32'hA);
    drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    out_ready = 1'b1;
    tick();
    chk("drain_head_b", alu_result, 32'hB);
    chk("drain_dest_b", {28'd0, dest}, 32'd2);
    chk("drain_rdy",    {31'd0, in_ready}, 32'd1);
    chk("drain_cnt",    {30'd0, count}, 32'd1);
    tick();
    chk_empty("drain_done");

    // Load select
    out_ready = 1'b0;
    drive(1'b1, 1'b1, 1'b1, 32'h40, 32'hDEAD, 4'd5);
    tick();
    chk("ld_wbv",  wb_value, 32'hDEAD);
    chk("ld_mren", {31'd0, mem_r_en}, 32'd1);
    drive(1'b1, 1'b1, 1'b0, 32'h40, 32'hDEAD, 4'd6);
    tick();
    drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    out_ready = 1'b1;
    tick();
    chk("alu_wbv",  wb_value, 32'h40);
    chk("alu_mrv",  mem_read_value, 32'hDEAD);
    chk("alu_dest", {28'd0, dest}, 32'd6);
    tick();
    chk_empty("ld_done");

    // Flush with concurrent push
    out_ready = 1'b0;
    drive(1'b1, 1'b1, 1'b0, 32'h11, 32'h0, 4'd7);
    tick();
    chk("pre_flush_cnt", {30'd0, count}, 32'd1);
    flush = 1'b1;
    drive(1'b1, 1'b1, 1'b0, 32'h99, 32'h0, 4'd8);
    tick();
    flush = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    chk_empty("flush");
    tick();
    chk_empty("flush_after");
    drive(1'b1, 1'b1, 1'b0, 32'h77, 32'h0, 4'd9);
    tick();
    chk("post_flush_head", alu_result, 32'h77);
    chk("post_flush_cnt",  {30'd0, count}, 32'd1);
    drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    out_ready = 1'b1;
    tick();
    chk_empty("post_flush_pop");

    // Streaming: 100 back-to-back entries
    out_ready = 1'b1;
    for (int i = 0; i < 100; i++) begin
      drive(1'b1, 1'b1, 1'b0, 32'(i + 1), 32'h0, 4'(i));
      chk("stream_rdy", {31'd0, in_ready}, 32'd1);
      tick();
      chk("stream_data", alu_result, 32'(i + 1));
      chk("stream_ov",   {31'd0, out_valid}, 32'd1);
    end
    drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    tick();
    chk_empty("stream_done");

    // Async reset mid-operation
    out_ready = 1'b0;
    drive(1'b1, 1'b1, 1'b1, 32'h21, 32'h31, 4'd1);
    tick();
    drive(1'b1, 1'b1, 1'b0, 32'h22, 32'h32, 4'd2);
    tick();
    drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    chk("arst_pre_cnt", {30'd0, count}, 32'd2);
    #1 reset_n = 1'b0;
    #1;
    chk_empty("arst");
    reset_n = 1'b1;
    drive(1'b1, 1'b1, 1'b0, 32'h55, 32'h0, 4'd10);
    tick();
    chk("arst_resume_head", alu_result, 32'h55);
    chk("arst_resume_cnt",  {30'd0, count}, 32'd1);
    drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    out_ready = 1'b1;
    tick();
    chk_empty("arst_resume_pop");

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

// File: doc/mem_wb_elastic_reg.md
# mem_wb_elastic_reg

Parametrised MEM→WB pipeline stage register. It replaces the fixed single-flop MEM/WB register with an elastic buffer of DEPTH entries. The buffer has a valid/ready handshake on both sides, a synchronous flush, and an optional write-back value select. It sits between the memory stage and the register-file write port, so the memory stage can keep issuing while write-back is stalled.

## Interface
Parameters:
- DATA_W, 32, width of ALU result, memory read value and write-back value
- DEST_W, 4, register-file address width
- DEPTH, 2, number of buffer entries; power of two, ≥2
- WB_SEL, 1, 1 = drive wb_value as the MEM_R_en-selected value; 0 = wb_value tied to 0

Ports:
- clk  in  1  rising-edge clock, the only clock
- reset_n  in  1  asynchronous, active-low reset
- flush  in  1  synchronous discard of all entries and of any concurrent push
- in_valid  in  1  upstream entry present
- in_ready  out  1  buffer can accept an entry; registered, = (count < DEPTH)
- wb_en_in  in  1  write-back enable
- mem_r_en_in  in  1  entry is a load
- alu_result_in  in  DATA_W  ALU result
- mem_read_value_in  in  DATA_W  memory read data
- dest_in  in  DEST_W  destination register
- out_valid  out  1  head entry present (count ≠ 0)
- out_ready  in  1  write-back consumes head this cycle
- wb_en, mem_r_en  out  1 each  head fields, gated by out_valid
- alu_result, mem_read_value  out  DATA_W each  head fields, gated by out_valid
- dest  out  DEST_W  head field, gated by out_valid
- wb_value  out  DATA_W  WB_SEL=1: mem_r_en ? mem_read_value : alu_result; gated by out_valid
- count  out  $clog2(DEPTH)+1  occupancy

## Operation
- Push: occurs when in_valid && in_ready && !flush. The entry is written at wr_ptr, and wr_ptr increments modulo DEPTH.
- Pop: occurs when out_valid && out_ready && !flush. rd_ptr increments modulo DEPTH.
- Simultaneous push and pop: count is unchanged and both pointers advance. This is legal only when 0 < count < DEPTH.
- Full: when count == DEPTH, in_ready = 0. No push occurs even if a pop occurs in the same cycle, because ready is registered and has no combinational path from out_ready.
- Empty: when count == 0, out_valid = 0 and every data output is 0.
- Gating:
  - When out_valid = 0, wb_en, mem_r_en, alu_result, mem_read_value, dest and wb_value are all 0.
  - This guarantees no spurious register-file write.
- Flush:
  - Takes priority over push and pop.
  - At the clock edge, count = 0 and wr_ptr = rd_ptr = 0.
  - The concurrent input is dropped.
  - Storage contents are don't-care.
- Entries with wb_en_in = 0 (bubbles) are stored and popped like any other entry; they are not filtered.
- Ordering is strict FIFO, with no reordering or bypass.
- Reset: while reset_n is low, count = 0, both pointers = 0, in_ready = 1, out_valid = 0, and all data outputs = 0. Reset asserted in the middle of operation discards all entries immediately, without waiting for a clock edge.

## Timing
- Latency: an entry pushed at edge N appears on the outputs after edge N, so write-back can consume it in cycle N+1.
- in_ready changes only at clock edges. It goes low on the edge on which count reaches DEPTH, and high on the edge after the first pop from full.
- Throughput: one entry per cycle sustained for DEPTH ≥ 2 when out_ready is held high.
- out_valid falls on the same edge as a flush; in_ready is 1 after that edge.
- Deassertion of reset_n is used synchronously. The first push can occur on the first edge after reset_n is sampled high.

## Structure
- Package arm_pipe_pkg:
  - typedef mem_wb_t, a packed struct {wb_en, mem_r_en, alu_result, mem_read_value, dest}, parametrised through package localparams DATA_W_DEF and DEST_W_DEF.
  - Function wb_select(mem_wb_t).
- One sub-module, elastic_fifo_ctrl. It holds the pointers, the count, in_ready and out_valid, and generates the push and pop strobes from flush, the handshake inputs and DEPTH.
- Top level: the storage array of mem_wb_t, the head read mux, the output gating and the wb_value mux.

## Test plan
- Reset then single push: push alu_result=0x1234, dest=3, wb_en=1 with out_ready=1. Required: out_valid=1 with those values one cycle later; count returns to 0 after the pop; no other outputs are nonzero.
- Fill with stall: out_ready=0, push 0xA, 0xB (DEPTH=2). Required: count=2, in_ready=0, and a third in_valid is not accepted. Then raise out_ready; required: outputs 0xA then 0xB in order, and in_ready=1 one edge after the first pop.
- Load select: push mem_r_en=1, mem_read_value=0xDEAD, alu_result=0x40. Required: wb_value=0xDEAD. Push mem_r_en=0; required: wb_value=0x40.
- Flush with concurrent push: count=1 when flush=1 and in_valid=1. Required: count=0 and out_valid=0 after the edge; the pushed entry never appears.
- Streaming: out_ready held 1, 100 back-to-back pushes of incrementing values. Required: 100 in-order outputs, and in_ready never deasserts.
- Async reset mid-operation: count=2 when reset_n pulses low between edges. Required: out_valid=0, all data outputs 0 and in_ready=1 immediately, and normal operation resumes afterwards.
